// File: rtl/iterative_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in EXE.
// Holds the pipeline via o_stall and releases it in the single cycle the results are valid.
module iterative_divider (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_start,
    input  logic        i_is_signed,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    input  logic        i_flush,
    output logic        o_stall,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [5:0]  count_q, count_d;
    // Partial remainder stays below the divisor, so bit 32 is only needed in rem_shift/trial.
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] raw_q, raw_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rmd_q, rmd_d;
    logic        q_sign_q, q_sign_d;
    logic        r_sign_q, r_sign_d;
    logic        div0_q, div0_d;

    logic [32:0] rem_shift;
    logic [32:0] trial;
    logic        q_bit;
    logic [31:0] rem_step;
    logic [31:0] quo_raw;
    logic        dvd_neg;
    logic        dvs_neg;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        raw_d    = raw_q;
        quo_d    = quo_q;
        rmd_d    = rmd_q;
        q_sign_d = q_sign_q;
        r_sign_d = r_sign_q;
        div0_d   = div0_q;

        rem_shift = {1'b0, rem_q, dvd_q[31]};
        trial     = rem_shift - {1'b0, dvs_q};
        q_bit     = ~trial[32];
        rem_step  = q_bit ? trial[31:0] : rem_shift[31:0];
        quo_raw   = {dvd_q[30:0], q_bit};
        dvd_neg   = i_is_signed & i_dividend[31];
        dvs_neg   = i_is_signed & i_divisor[31];

        unique case (state_q)
            StIdle: begin
                if (i_start && !i_flush) begin
                    state_d  = StRun;
                    dvd_d    = dvd_neg ? (~i_dividend + 32'd1) : i_dividend;
                    dvs_d    = dvs_neg ? (~i_divisor + 32'd1) : i_divisor;
                    raw_d    = i_dividend;
                    q_sign_d = dvd_neg ^ dvs_neg;
                    r_sign_d = dvd_neg;
                    div0_d   = (i_divisor == 32'd0);
                    rem_d    = 32'd0;
                    count_d  = 6'd32;
                end
            end
            StRun: begin
                rem_d   = rem_step;
                dvd_d   = quo_raw;
                count_d = count_q - 6'd1;
                if (count_q == 6'd1) begin
                    state_d = StDone;
                    if (div0_q) begin
                        quo_d = 32'hFFFF_FFFF;
                        rmd_d = raw_q;
                    end else begin
                        quo_d = q_sign_q ? (~quo_raw + 32'd1) : quo_raw;
                        rmd_d = r_sign_q ? (~rem_step + 32'd1) : rem_step;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Flush aborts from any state and must not disturb the published results.
        if (i_flush) begin
            state_d = StIdle;
            quo_d   = quo_q;
            rmd_d   = rmd_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            count_q  <= 6'd0;
            rem_q    <= 32'd0;
            dvd_q    <= 32'd0;
            dvs_q    <= 32'd0;
            raw_q    <= 32'd0;
            quo_q    <= 32'd0;
            rmd_q    <= 32'd0;
            q_sign_q <= 1'b0;
            r_sign_q <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            raw_q    <= raw_d;
            quo_q    <= quo_d;
            rmd_q    <= rmd_d;
            q_sign_q <= q_sign_d;
            r_sign_q <= r_sign_d;
            div0_q   <= div0_d;
        end
    end

    assign o_busy      = (state_q == StRun);
    assign o_done      = (state_q == StDone) && !i_flush;
    assign o_stall     = ((state_q == StIdle) && i_start && !i_flush) || (state_q == StRun);
    assign o_quotient  = quo_q;
    assign o_remainder = rmd_q;

endmodule
